// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a shared single-ported memory
//
// Shares one word-addressed memory between the fetch port (if_*) and the
// data port (dm_*). Data wins by default. A streak counter forces a fetch
// grant after MAX_DATA_STREAK consecutive data wins against a waiting fetch.
// Read data is routed back to the issuing port one cycle after its grant.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   if_req/if_addr -> if_gnt         fetch request handshake (read only)
//   if_rvalid/if_rdata               fetch read response
//   dm_req/dm_we/dm_addr/dm_wdata    data request (load or store)
//   dm_gnt, dm_rvalid/dm_rdata       data grant and load response
//   mem_en/mem_we/mem_addr/mem_wdata memory command
//   mem_rdata                        memory read data, one cycle after mem_en

module mem_port_arbiter #(
    parameter int AW              = 10,
    parameter int DW              = 32,
    parameter int MAX_DATA_STREAK = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);

    logic [3:0] streak_q, streak_d;
    logic       resp_valid_q, resp_valid_d;
    logic       resp_owner_q, resp_owner_d;
    logic       force_fetch;

    assign force_fetch = (streak_q == MAX_STREAK);

    // Grants are masked while reset is asserted so no access leaks out
    // even though requesters may still be driving req.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (rst_n) begin
            if (dm_req && !(if_req && force_fetch)) begin
                dm_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = if_gnt | dm_gnt;
        mem_we    = dm_gnt & dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_gnt) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    // Streak counts only data wins that made a fetch wait; any cycle without
    // a waiting fetch restarts it. Saturation is implicit: at MAX_STREAK with
    // both requesting, fetch wins and clears it.
    always_comb begin
        streak_d = streak_q;
        if (if_gnt || !if_req) begin
            streak_d = 4'd0;
        end else if (dm_gnt) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_comb begin
        resp_valid_d = if_gnt | (dm_gnt & ~dm_we);
        resp_owner_d = dm_gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q     <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_owner_q <= 1'b0;
        end else begin
            streak_q     <= streak_d;
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
        end
    end

    assign if_rvalid = resp_valid_q & ~resp_owner_q;
    assign dm_rvalid = resp_valid_q &  resp_owner_q;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard testbench for mem_port_arbiter

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, dm_req, dm_we;
    logic [9:0]  if_addr, dm_addr;
    logic [31:0] dm_wdata;
    logic        if_gnt, dm_gnt, if_rvalid, dm_rvalid;
    logic [31:0] if_rdata, dm_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit          owner;
        logic [31:0] data;
        int          cyc;
    } resp_t;
    resp_t sb[$];

    logic [31:0] mem     [1024];
    logic [31:0] exp_mem [1024];

    mem_port_arbiter #(.AW(10), .DW(32), .MAX_DATA_STREAK(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Single-ported memory: write at the grant edge, read data one cycle later.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every rvalid must match the oldest queued read,
    // land on the right port and arrive exactly one cycle after its grant.
    always @(negedge clk) begin
        if (if_rvalid || dm_rvalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", {30'd0, dm_rvalid, if_rvalid}, 32'd0);
            end else begin
                resp_t e;
                e = sb.pop_front();
                chk("resp_if_rvalid", {31'd0, if_rvalid}, {31'd0, ~e.owner});
                chk("resp_dm_rvalid", {31'd0, dm_rvalid}, {31'd0, e.owner});
                chk("resp_latency", cyc, e.cyc + 1);
                if (e.owner) begin
                    chk("dm_rdata", dm_rdata, e.data);
                    chk("if_rdata_idle", if_rdata, 32'd0);
                end else begin
                    chk("if_rdata", if_rdata, e.data);
                    chk("dm_rdata_idle", dm_rdata, 32'd0);
                end
            end
        end
    end

    task automatic drive(input bit ir, input logic [9:0] ia, input bit dr, input bit dw,
                         input logic [9:0] da, input logic [31:0] wd);
        if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = wd;
    endtask

    task automatic step(input bit ir, input logic [9:0] ia, input bit dr, input bit dw,
                        input logic [9:0] da, input logic [31:0] wd,
                        input bit eif, input bit edm, input string name);
        logic [9:0] ea;
        @(posedge clk); #1;
        drive(ir, ia, dr, dw, da, wd);
        @(negedge clk);
        ea = eif ? ia : (edm ? da : 10'd0);
        chk({name, "_if_gnt"}, {31'd0, if_gnt}, {31'd0, eif});
        chk({name, "_dm_gnt"}, {31'd0, dm_gnt}, {31'd0, edm});
        chk({name, "_mem_en"}, {31'd0, mem_en}, {31'd0, eif | edm});
        chk({name, "_mem_we"}, {31'd0, mem_we}, {31'd0, edm & dw});
        chk({name, "_mem_addr"}, {22'd0, mem_addr}, {22'd0, ea});
        if (edm)             chk({name, "_mem_wdata"}, mem_wdata, wd);
        else if (!eif)       chk({name, "_mem_wdata"}, mem_wdata, 32'd0);
        if (eif)             sb.push_back('{1'b0, exp_mem[ia], cyc});
        if (edm && !dw)      sb.push_back('{1'b1, exp_mem[da], cyc});
        if (edm && dw)       exp_mem[da] = wd;
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_if_gnt"},    {31'd0, if_gnt},    32'd0);
        chk({name, "_dm_gnt"},    {31'd0, dm_gnt},    32'd0);
        chk({name, "_mem_en"},    {31'd0, mem_en},    32'd0);
        chk({name, "_mem_we"},    {31'd0, mem_we},    32'd0);
        chk({name, "_if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
        chk({name, "_dm_rvalid"}, {31'd0, dm_rvalid}, 32'd0);
        chk({name, "_if_rdata"},  if_rdata,           32'd0);
        chk({name, "_dm_rdata"},  dm_rdata,           32'd0);
    endtask

    // Pulse reset after a read grant has been checked but before its edge;
    // the pending response is dropped from the scoreboard.
    task automatic reset_pulse(input string name);
        #2 rst_n = 1'b0;
        if (sb.size() > 0) sb.delete(sb.size() - 1);
        #1 check_reset_outputs({name, "_during"});
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_reset_outputs({name, "_held"});
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf, nd;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = (i < 3) ? 32'(32'h11 * (i + 1)) : (32'h5A00_0000 | 32'(i));
            exp_mem[i] = (i < 3) ? 32'(32'h11 * (i + 1)) : (32'h5A00_0000 | 32'(i));
        end
        mem_rdata = '0;

        // Reset with both requesters active: everything stays quiet.
        rst_n = 1'b0;
        drive(1, 10'h10, 1, 0, 10'h20, 0);
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Starvation guard: D,D,D,F,D,D,D,F with held requests.
        nf = 0; nd = 0;
        for (int g = 0; g < 8; g++) begin
            bit f;
            f = (g % 4 == 3);
            step(1, 10'(10'h10 + nf), 1, 0, 10'(10'h20 + nd), 0, f, !f, "starve");
            if (f) nf++; else nd++;
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, "idle0");

        // Fetch-only stream at addresses 0,1,2.
        for (int a = 0; a < 3; a++) step(1, 10'(a), 0, 0, 0, 0, 1, 0, "fetch");
        step(0, 0, 0, 0, 0, 0, 0, 0, "idle1");

        // Store then load same address; top-of-range address passes through.
        step(0, 0, 1, 1, 10'd5, 32'hDEADBEEF, 0, 1, "store5");
        step(0, 0, 1, 0, 10'd5, 0, 0, 1, "load5");
        step(0, 0, 1, 1, 10'h3FF, 32'hCAFEF00D, 0, 1, "store3ff");
        step(0, 0, 0, 0, 0, 0, 0, 0, "idle2");
        step(1, 10'h3FF, 0, 0, 0, 0, 1, 0, "fetch3ff");
        step(0, 0, 1, 0, 10'h3FF, 0, 0, 1, "load3ff");

        // Idle gaps between single requests.
        step(1, 10'd7, 0, 0, 0, 0, 1, 0, "gap_fetch");
        step(0, 0, 0, 0, 0, 0, 0, 0, "gap_idle_a");
        step(0, 0, 1, 0, 10'd8, 0, 0, 1, "gap_load");
        step(0, 0, 0, 0, 0, 0, 0, 0, "gap_idle_b");
        step(0, 0, 1, 1, 10'd9, 32'h0000_0999, 0, 1, "gap_store");
        step(0, 0, 0, 0, 0, 0, 0, 0, "gap_idle_c");
        step(0, 0, 1, 0, 10'd9, 0, 0, 1, "gap_load9");

        // Forced fetch wins over a pending store; the store waits.
        step(1, 10'h30, 1, 1, 10'h40, 32'hA0, 0, 1, "fst0");
        step(1, 10'h30, 1, 1, 10'h41, 32'hA1, 0, 1, "fst1");
        step(1, 10'h30, 1, 1, 10'h42, 32'hA2, 0, 1, "fst2");
        step(1, 10'h30, 1, 1, 10'h43, 32'hA3, 1, 0, "fst_force");
        step(0, 0, 1, 1, 10'h43, 32'hA3, 0, 1, "fst3");
        step(0, 0, 1, 0, 10'h43, 0, 0, 1, "fst_load");

        // Reset mid fetch read: response is discarded.
        step(1, 10'd1, 0, 0, 0, 0, 1, 0, "rst_fetch");
        reset_pulse("rst1");

        // Reset mid data streak: streak restarts from 0 afterwards.
        step(1, 10'h50, 1, 0, 10'h60, 0, 0, 1, "rs_d0");
        step(1, 10'h50, 1, 0, 10'h61, 0, 0, 1, "rs_d1");
        step(1, 10'h50, 1, 0, 10'h62, 0, 0, 1, "rs_d2");
        reset_pulse("rst2");
        step(1, 10'h50, 1, 0, 10'h63, 0, 0, 1, "post_d0");
        step(1, 10'h50, 1, 0, 10'h64, 0, 0, 1, "post_d1");
        step(1, 10'h50, 1, 0, 10'h65, 0, 0, 1, "post_d2");
        step(1, 10'h50, 1, 0, 10'h66, 0, 1, 0, "post_f");

        step(0, 0, 0, 0, 0, 0, 0, 0, "tail0");
        step(0, 0, 0, 0, 0, 0, 0, 0, "tail1");
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
